branch_tag_ctrl: RTL and testbench

// - Owns the speculative branch-tag pool shared by ALUrs/LSrs: allocates a tag per dispatched branch,

---
 rtl/branch_tag_ctrl.sv | 118 +++++++++++
 tb/tb_branch_tag_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_tag_ctrl.sv
// Speculative branch-tag pool: allocates tags, tracks older-tag dependencies, and registers the free/flush broadcast.
// Optional resolve/mispredict statistics counters are enabled by defining BRTAG_STAT_EN.
module branch_tag_ctrl #(
    parameter int BR_NUM = 4,
    parameter int BR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              allocReq,
    output logic              allocGrant,
    output logic [BR_W-1:0]   allocNum,
    output logic [BR_NUM-1:0] curBranchTag,
    output logic              full,
    output logic              flushReq,
    input  logic              resolveEn,
    input  logic [BR_W-1:0]   resolveNum,
    input  logic              resolveMis,
    output logic              bFreeEn,
    output logic [BR_W-1:0]   bFreeNum,
    output logic              misTaken
`ifdef BRTAG_STAT_EN
    ,
    output logic [15:0]       statResolve,
    output logic [15:0]       statMis
`endif
);

    logic [BR_NUM-1:0] active, active_nxt;
    logic [BR_NUM-1:0] dep     [BR_NUM];
    logic [BR_NUM-1:0] dep_nxt [BR_NUM];
    logic [BR_NUM-1:0] res_onehot;
    logic [BR_NUM-1:0] resolved_bit;
    logic [BR_NUM-1:0] kill;
    logic              resolve_valid;

    assign resolve_valid = resolveEn & active[resolveNum];
    assign res_onehot    = {{(BR_NUM-1){1'b0}}, 1'b1} << resolveNum;
    assign resolved_bit  = (resolve_valid & ~resolveMis) ? res_onehot : '0;

    assign full         = &active;
    assign flushReq     = resolveEn & resolveMis;
    assign allocGrant   = allocReq & ~full & ~flushReq;
    assign curBranchTag = active;

    // Descending scan so the lowest free index wins; defaults to 0 when none is free.
    always_comb begin
        allocNum = '0;
        for (int i = BR_NUM - 1; i >= 0; i--) begin
            if (!active[i]) allocNum = BR_W'(i);
        end
    end

    // A mispredict kills the resolved tag plus every live tag that was allocated behind it.
    always_comb begin
        kill = '0;
        if (resolve_valid && resolveMis) begin
            kill = res_onehot;
            for (int k = 0; k < BR_NUM; k++) begin
                if (dep[k][resolveNum]) kill[k] = 1'b1;
            end
            kill = kill & active;
        end
    end

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        active_nxt = active;
        dep_nxt    = dep;
        if (resolve_valid) begin
            if (resolveMis) begin
                active_nxt = active & ~kill;
                for (int k = 0; k < BR_NUM; k++) begin
                    if (kill[k]) dep_nxt[k] = '0;
                end
            end else begin
                active_nxt[resolveNum] = 1'b0;
                for (int k = 0; k < BR_NUM; k++) begin
                    dep_nxt[k][resolveNum] = 1'b0;
                end
            end
        end
        if (allocGrant) begin
            active_nxt[allocNum] = 1'b1;
            dep_nxt[allocNum]    = active & ~resolved_bit;
        end
    end

    // NOTE: the dependency array is small and its contents must read as zero after reset, so it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= '0;
            bFreeEn  <= 1'b0;
            bFreeNum <= '0;
            misTaken <= 1'b0;
            for (int k = 0; k < BR_NUM; k++) dep[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            active   <= active_nxt;
            dep      <= dep_nxt;
            bFreeEn  <= resolve_valid;
            misTaken <= resolve_valid & resolveMis;
            if (resolve_valid) bFreeNum <= resolveNum;
        end
    end

`ifdef BRTAG_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            statResolve <= '0;
            statMis     <= '0;
        end else begin
            if (resolve_valid && statResolve != 16'hFFFF) statResolve <= statResolve + 16'd1;
            if (resolve_valid && resolveMis && statMis != 16'hFFFF) statMis <= statMis + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Self-checking bench for branch_tag_ctrl: directed scenarios plus randomized traffic against an age-ordered queue model.
// Define BRTAG_STAT_EN for both files to also check the statistics counters.
module tb_branch_tag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       allocReq;
    logic       allocGrant;
    logic [1:0] allocNum;
    logic [3:0] curBranchTag;
    logic       full;
    logic       flushReq;
    logic       resolveEn;
    logic [1:0] resolveNum;
    logic       resolveMis;
    logic       bFreeEn;
    logic [1:0] bFreeNum;
    logic       misTaken;
`ifdef BRTAG_STAT_EN
    logic [15:0] statResolve;
    logic [15:0] statMis;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_tag_ctrl #(.BR_NUM(4), .BR_W(2)) dut (
        .clk(clk), .rst(rst),
        .allocReq(allocReq), .allocGrant(allocGrant), .allocNum(allocNum),
        .curBranchTag(curBranchTag), .full(full), .flushReq(flushReq),
        .resolveEn(resolveEn), .resolveNum(resolveNum), .resolveMis(resolveMis),
        .bFreeEn(bFreeEn), .bFreeNum(bFreeNum), .misTaken(misTaken)
`ifdef BRTAG_STAT_EN
        , .statResolve(statResolve), .statMis(statMis)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: in-flight tags kept oldest-first; a tag's dependencies are simply those ahead of it.
    int         q[$];
    bit         m_bfree_en;
    int         m_bfree_num;
    bit         m_mis;
    int         m_sres;
    int         m_smis;

    function automatic logic [3:0] m_mask();
        logic [3:0] m = '0;
        foreach (q[i]) m[q[i]] = 1'b1;
        return m;
    endfunction

    function automatic int m_free(input logic [3:0] msk);
        for (int i = 0; i < 4; i++) if (!msk[i]) return i;
        return 0;
    endfunction

    function automatic bit m_grant();
        return allocReq && (m_mask() != 4'hF) && !(resolveEn && resolveMis);
    endfunction

    task automatic model_step();
        logic [3:0] msk;
        bit grant, valid;
        int an, pos;
        msk = m_mask();
        if (rst) begin
            q.delete();
            m_bfree_en = 0; m_bfree_num = 0; m_mis = 0; m_sres = 0; m_smis = 0;
            return;
        end
        grant = m_grant();
        an    = m_free(msk);
        valid = resolveEn && msk[resolveNum];
        m_bfree_en = valid;
        m_mis      = valid && resolveMis;
        if (valid) begin
            m_bfree_num = int'(resolveNum);
            pos = 0;
            foreach (q[i]) if (q[i] == int'(resolveNum)) pos = i;
            if (resolveMis) begin
                while (q.size() > pos) void'(q.pop_back());
                if (m_smis < 16'hFFFF) m_smis++;
            end else begin
                q.delete(pos);
            end
            if (m_sres < 16'hFFFF) m_sres++;
        end
        if (grant) q.push_back(an);
    endtask

    task automatic set_in(input bit req, input bit en, input int num, input bit mis);
        allocReq   = req;
        resolveEn  = en;
        resolveNum = 2'(num);
        resolveMis = mis;
        #1;
    endtask

    task automatic clk_edge();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        clk_edge();
        clk_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (curBranchTag !== 4'b0000 || full !== 1'b0 || bFreeEn !== 1'b0 || bFreeNum !== 2'd0 || misTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: tag=%b full=%b bFreeEn=%b bFreeNum=%0d misTaken=%b, want 0000 0 0 0 0",
                     curBranchTag, full, bFreeEn, bFreeNum, misTaken);
        end
`ifdef BRTAG_STAT_EN
        n_checks++;
        if (statResolve !== 16'd0 || statMis !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stat: res=%0d mis=%0d, want 0 0", statResolve, statMis);
        end
`endif
    endtask

    task automatic test_fill();
        logic [3:0] exp_tag;
        exp_tag = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0);
            n_checks++;
            if (allocGrant !== 1'b1 || allocNum !== 2'(i) || curBranchTag !== exp_tag) begin
                n_fail++;
                $display("FAIL fill_%0d: grant=%b num=%0d tag=%b, want 1 %0d %b", i, allocGrant, allocNum, curBranchTag, i, exp_tag);
            end
            clk_edge();
            exp_tag[i] = 1'b1;
        end
        set_in(1, 0, 0, 0);
        n_checks++;
        if (full !== 1'b1 || allocGrant !== 1'b0 || curBranchTag !== 4'b1111) begin
            n_fail++;
            $display("FAIL fill_full: full=%b grant=%b tag=%b, want 1 0 1111", full, allocGrant, curBranchTag);
        end
        clk_edge();
    endtask

    task automatic test_correct_resolve();
        set_in(0, 1, 1, 0);
        n_checks++;
        if (flushReq !== 1'b0) begin
            n_fail++;
            $display("FAIL correct_flush: flushReq=%b want 0", flushReq);
        end
        clk_edge();
        set_in(1, 0, 0, 0);
        n_checks++;
        if (bFreeEn !== 1'b1 || bFreeNum !== 2'd1 || misTaken !== 1'b0 || curBranchTag !== 4'b1101) begin
            n_fail++;
            $display("FAIL correct_bcast: en=%b num=%0d mis=%b tag=%b, want 1 1 0 1101", bFreeEn, bFreeNum, misTaken, curBranchTag);
        end
        n_checks++;
        if (allocGrant !== 1'b1 || allocNum !== 2'd1) begin
            n_fail++;
            $display("FAIL correct_realloc: grant=%b num=%0d, want 1 1", allocGrant, allocNum);
        end
        clk_edge();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (bFreeEn !== 1'b0 || misTaken !== 1'b0 || curBranchTag !== 4'b1111) begin
            n_fail++;
            $display("FAIL correct_oneshot: en=%b mis=%b tag=%b, want 0 0 1111", bFreeEn, misTaken, curBranchTag);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0);
            clk_edge();
        end
        set_in(1, 1, 1, 1);
        n_checks++;
        if (flushReq !== 1'b1 || allocGrant !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_flush: flushReq=%b grant=%b, want 1 0", flushReq, allocGrant);
        end
        clk_edge();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (bFreeEn !== 1'b1 || bFreeNum !== 2'd1 || misTaken !== 1'b1 || curBranchTag !== 4'b0001) begin
            n_fail++;
            $display("FAIL mis_bcast: en=%b num=%0d mis=%b tag=%b, want 1 1 1 0001", bFreeEn, bFreeNum, misTaken, curBranchTag);
        end
    endtask

    task automatic test_alloc_resolve_same();
        set_in(1, 1, 0, 0);
        n_checks++;
        if (allocGrant !== 1'b1 || allocNum !== 2'd1) begin
            n_fail++;
            $display("FAIL same_grant: grant=%b num=%0d, want 1 1", allocGrant, allocNum);
        end
        clk_edge();
        set_in(1, 0, 0, 0);
        n_checks++;
        if (curBranchTag !== 4'b0010 || bFreeEn !== 1'b1 || bFreeNum !== 2'd0) begin
            n_fail++;
            $display("FAIL same_state: tag=%b en=%b num=%0d, want 0010 1 0", curBranchTag, bFreeEn, bFreeNum);
        end
        // Tag 1 must not depend on the freed tag 0, so killing the newly allocated tag 0 must spare it.
        clk_edge();
        set_in(0, 1, 0, 1);
        clk_edge();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (curBranchTag !== 4'b0010) begin
            n_fail++;
            $display("FAIL same_dep: tag=%b want 0010", curBranchTag);
        end
    endtask

    task automatic test_alloc_mispredict();
        do_reset();
        set_in(1, 0, 0, 0); clk_edge();
        set_in(1, 0, 0, 0); clk_edge();
        set_in(1, 1, 0, 1);
        n_checks++;
        if (allocGrant !== 1'b0 || flushReq !== 1'b1) begin
            n_fail++;
            $display("FAIL allocmis_grant: grant=%b flush=%b, want 0 1", allocGrant, flushReq);
        end
        clk_edge();
        set_in(0, 1, 3, 0);
        n_checks++;
        if (curBranchTag !== 4'b0000 || misTaken !== 1'b1) begin
            n_fail++;
            $display("FAIL allocmis_kill: tag=%b mis=%b, want 0000 1", curBranchTag, misTaken);
        end
        clk_edge();
        set_in(0, 1, 2, 1);
        n_checks++;
        if (bFreeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL inactive_resolve: bFreeEn=%b want 0", bFreeEn);
        end
        clk_edge();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (bFreeEn !== 1'b0 || misTaken !== 1'b0 || curBranchTag !== 4'b0000) begin
            n_fail++;
            $display("FAIL inactive_mis: en=%b mis=%b tag=%b, want 0 0 0000", bFreeEn, misTaken, curBranchTag);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0);
            clk_edge();
        end
        set_in(0, 1, 1, 0);
        clk_edge();
        rst = 1'b1;
        set_in(0, 1, 2, 1);
        clk_edge();
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        n_checks++;
        if (curBranchTag !== 4'b0000 || full !== 1'b0 || bFreeEn !== 1'b0 || bFreeNum !== 2'd0 || misTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: tag=%b full=%b en=%b num=%0d mis=%b, want 0000 0 0 0 0",
                     curBranchTag, full, bFreeEn, bFreeNum, misTaken);
        end
`ifdef BRTAG_STAT_EN
        n_checks++;
        if (statResolve !== 16'd0 || statMis !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_stat: res=%0d mis=%0d, want 0 0", statResolve, statMis);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] msk;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 9) < 3);
            msk = m_mask();
            n_checks++;
            if (allocGrant !== m_grant() || allocNum !== 2'(m_free(msk)) || full !== (msk == 4'hF) ||
                flushReq !== (resolveEn & resolveMis) || curBranchTag !== msk) begin
                n_fail++;
                $display("FAIL rand_comb c=%0d: grant=%b num=%0d full=%b flush=%b tag=%b, want %b %0d %b %b %b", c,
                         allocGrant, allocNum, full, flushReq, curBranchTag,
                         m_grant(), m_free(msk), msk == 4'hF, resolveEn & resolveMis, msk);
            end
            clk_edge();
            n_checks++;
            if (bFreeEn !== m_bfree_en || misTaken !== m_mis || (m_bfree_en && bFreeNum !== 2'(m_bfree_num)) ||
                curBranchTag !== m_mask()) begin
                n_fail++;
                $display("FAIL rand_reg c=%0d: en=%b mis=%b num=%0d tag=%b, want %b %b %0d %b", c,
                         bFreeEn, misTaken, bFreeNum, curBranchTag, m_bfree_en, m_mis, m_bfree_num, m_mask());
            end
`ifdef BRTAG_STAT_EN
            n_checks++;
            if (statResolve !== 16'(m_sres) || statMis !== 16'(m_smis)) begin
                n_fail++;
                $display("FAIL rand_stat c=%0d: res=%0d mis=%0d, want %0d %0d", c, statResolve, statMis, m_sres, m_smis);
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        test_reset();
        test_fill();
        test_correct_resolve();
        test_mispredict();
        test_alloc_resolve_same();
        test_alloc_mispredict();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
